// File: rtl/ppu_pkg.sv
// Shared types, constants and per-lane arithmetic helpers for the post-processing quantizer.
// Lane math: rounding arithmetic right shift, then optional ReLU and int8/int4 saturation.
package ppu_pkg;

  localparam int LANES = 16;
  localparam int ACC_W = 24;
  localparam int ROWS  = 16;
  localparam int OUT_W = 8;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] shift;
    logic       relu_en;
    logic       int4_out;
  } cfg_t;

  localparam logic signed [SUM_W-1:0] I8_MAX = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] I8_MIN = SUM_W'(-128);
  localparam logic signed [SUM_W-1:0] I4_MAX = SUM_W'(7);
  localparam logic signed [SUM_W-1:0] I4_MIN = SUM_W'(-8);

  // One extra bit of headroom keeps the rounding add from overflowing at full-scale input.
  function automatic logic signed [SUM_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a,
    input logic        [4:0]       sh
  );
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] rnd;
    ext = {a[ACC_W-1], a};
    rnd = (sh == 5'd0) ? '0 : (SUM_W'(1) << (sh - 5'd1));
    return (ext + rnd) >>> sh;
  endfunction

  function automatic logic [OUT_W-1:0] sat_lane(
    input logic signed [SUM_W-1:0] v,
    input logic                    relu,
    input logic                    int4
  );
    logic signed [SUM_W-1:0] x;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    x  = (relu && v[SUM_W-1]) ? '0 : v;
    hi = int4 ? I4_MAX : I8_MAX;
    lo = int4 ? I4_MIN : I8_MIN;
    if (x > hi) begin
      x = hi;
    end else if (x < lo) begin
      x = lo;
    end
    return x[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/ppu_fifo.sv
// Synchronous show-ahead FIFO: head_dat reflects the oldest entry whenever count is non-zero.
// Push and pop may coincide at any fill level; the producer is responsible for never overfilling.
module ppu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_vld, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it until count says an entry was written.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ppu_quant.sv
// Requantizes a 16-row tile of 24-bit lane sums to int8/int4 through a 2-stage pipeline into an output FIFO.
// Row accepted at edge N lands in the FIFO at N+2; input is credit-gated on FIFO space plus in-flight rows.
module ppu_quant #(
  parameter int LANES      = ppu_pkg::LANES,
  parameter int ACC_W      = ppu_pkg::ACC_W,
  parameter int ROWS       = ppu_pkg::ROWS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  input  logic                     int4_out,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*8-1:0]       out_data,
  output logic                     busy,
  output logic                     tile_done
);

  import ppu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = $clog2(ROWS);
  localparam int DW = LANES * OUT_W;

  state_e        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [RW-1:0] row_q, row_d;
  logic          tile_done_q, tile_done_d;

  logic                    s1_vld_q, s1_vld_d;
  logic signed [SUM_W-1:0] s1_q [LANES];
  logic signed [SUM_W-1:0] s1_d [LANES];
  logic                    s2_vld_q, s2_vld_d;
  logic [DW-1:0]           s2_q, s2_d;

  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_head;
  logic [CW:0]   occ;
  logic          accept;
  logic          pop;
  logic          drain_done;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign s1_d[i] = round_shift(in_data[i*ACC_W +: ACC_W], cfg_q.shift);
    assign s2_d[i*OUT_W +: OUT_W] = sat_lane(s1_q[i], cfg_q.relu_en, cfg_q.int4_out);
  end

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign occ       = {1'b0, fifo_count} + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q);

  // Last row leaves the block on the same edge that pops it, so finish is decided one edge early.
  assign drain_done = !s1_vld_q && !s2_vld_q &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      row_q       <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      row_q       <= row_d;
      tile_done_q <= tile_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    row_d       = row_q;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = RUN;
          cfg_d.shift    = shift;
          cfg_d.relu_en  = relu_en;
          cfg_d.int4_out = int4_out;
          row_d          = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = DRAIN;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d     = IDLE;
          tile_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN) && (occ < (CW+1)'(FIFO_DEPTH));
    busy     = (state_q != IDLE);
  end

  always_comb begin
    s1_vld_d = accept;
    s2_vld_d = s1_vld_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i] <= '0;
      end
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s2_q     <= s2_d;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i] <= s1_d[i];
      end
    end
  end

  ppu_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (s2_vld_q),
    .push_dat (s2_q),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );

  // Head storage is unreset, so the visible data is forced to zero while nothing is valid.
  assign out_data  = out_valid ? fifo_head : '0;
  assign tile_done = tile_done_q;

endmodule

// File: tb/tb_ppu_quant.sv
// Directed bench for ppu_quant: rounding/saturation vectors, streaming, backpressure,
// mid-tile reset and start-while-busy, each checked against hand-derived expectations.
module tb_ppu_quant;

  localparam int LANES = 16;
  localparam int ACC_W = 24;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [4:0]             shift;
  logic                   relu_en;
  logic                   int4_out;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*8-1:0]     out_data;
  logic                   busy;
  logic                   tile_done;

  int checks = 0;
  int errors = 0;

  logic [LANES*ACC_W-1:0] rows    [16];
  logic [LANES*8-1:0]     exp_out [16];

  ppu_quant dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .shift     (shift),
    .relu_en   (relu_en),
    .int4_out  (int4_out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .tile_done (tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // shift=3, int8: rounding half-up on both signs and negative saturation.
  task automatic fill_t1();
    for (int r = 0; r < 16; r++) begin
      rows[r] = '0;
      rows[r][0*24 +: 24]  = 24'(1000);
      rows[r][1*24 +: 24]  = 24'(-1000);
      rows[r][2*24 +: 24]  = 24'(8 * r);
      rows[r][3*24 +: 24]  = 24'(12);
      rows[r][4*24 +: 24]  = 24'(-12);
      rows[r][5*24 +: 24]  = 24'(-20000);
      rows[r][15*24 +: 24] = 24'(-8 * r);
      exp_out[r] = '0;
      exp_out[r][0*8 +: 8]  = 8'h7D;
      exp_out[r][1*8 +: 8]  = 8'h83;
      exp_out[r][2*8 +: 8]  = 8'(r);
      exp_out[r][3*8 +: 8]  = 8'h02;
      exp_out[r][4*8 +: 8]  = 8'hFF;
      exp_out[r][5*8 +: 8]  = 8'h80;
      exp_out[r][15*8 +: 8] = 8'(-r);
    end
  endtask

  // shift=4, ReLU, int4.
  task automatic fill_t3();
    for (int r = 0; r < 16; r++) begin
      rows[r] = '0;
      rows[r][0*24 +: 24] = 24'(-500);
      rows[r][1*24 +: 24] = 24'(100);
      rows[r][2*24 +: 24] = 24'(200);
      rows[r][3*24 +: 24] = 24'(16 * r);
      rows[r][4*24 +: 24] = 24'(-16 * r);
      exp_out[r] = '0;
      exp_out[r][0*8 +: 8] = 8'h00;
      exp_out[r][1*8 +: 8] = 8'h06;
      exp_out[r][2*8 +: 8] = 8'h07;
      exp_out[r][3*8 +: 8] = (r > 7) ? 8'h07 : 8'(r);
      exp_out[r][4*8 +: 8] = 8'h00;
    end
  endtask

  // shift=4, int8: positive saturation, full-scale input, exact halves.
  task automatic fill_t4();
    for (int r = 0; r < 16; r++) begin
      rows[r] = '0;
      rows[r][0*24 +: 24]  = 24'(70000);
      rows[r][1*24 +: 24]  = 24'(-70000);
      rows[r][2*24 +: 24]  = 24'(16 * r + 8);
      rows[r][3*24 +: 24]  = 24'(-16 * r - 8);
      rows[r][15*24 +: 24] = 24'h7FFFFF;
      exp_out[r] = '0;
      exp_out[r][0*8 +: 8]  = 8'h7F;
      exp_out[r][1*8 +: 8]  = 8'h80;
      exp_out[r][2*8 +: 8]  = 8'(r + 1);
      exp_out[r][3*8 +: 8]  = 8'(-r);
      exp_out[r][15*8 +: 8] = 8'h7F;
    end
  endtask

  // Runs one tile from rows[]; out_ready stays low for the first 'hold' cycles.
  task automatic stream_tile(input logic [4:0] sh, input logic rl, input logic i4,
                             input int hold, input int restart_k, input string tag);
    int   next_in, out_idx, first_acc, last_acc, first_out, last_pop;
    int   done_k, done_cnt, acc_at_release;
    logic busy_at_done, rdy_at_release;
    next_in = 0; out_idx = 0; first_acc = -1; last_acc = -1; first_out = -1;
    last_pop = -1; done_k = -1; done_cnt = 0; acc_at_release = -1;
    busy_at_done = 1'b1; rdy_at_release = 1'b1;

    @(negedge clk);
    start = 1'b1; shift = sh; relu_en = rl; int4_out = i4;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1'b1);
    check({tag, "_rdy_after_start"}, in_ready, 1'b1);

    for (int k = 0; k < 300; k++) begin
      if (done_cnt > 0 && k > done_k + 3) break;
      if (k == restart_k) begin
        start = 1'b1; shift = 5'd0; relu_en = 1'b0; int4_out = 1'b0;
      end else begin
        start = 1'b0;
      end
      out_ready = (k >= hold);
      if (k == hold && hold > 0) begin
        acc_at_release = next_in;
        rdy_at_release = in_ready;
      end
      if (tile_done) begin
        done_cnt++;
        done_k = k;
        busy_at_done = busy;
      end
      if (out_valid) begin
        if (out_idx < 16) begin
          check($sformatf("%s_row%0d", tag, out_idx), out_data, exp_out[out_idx]);
        end else begin
          check({tag, "_extra_output"}, out_valid, 1'b0);
        end
        if (first_out < 0) first_out = k;
        if (out_ready) begin
          last_pop = k;
          out_idx++;
        end
      end
      in_valid = (next_in < 16);
      in_data  = (next_in < 16) ? rows[next_in] : '0;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = k;
        last_acc = k;
        next_in++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;

    check({tag, "_rows_out"}, 128'(out_idx), 128'(16));
    check({tag, "_done_count"}, 128'(done_cnt), 128'(1));
    check({tag, "_done_after_last_pop"}, 128'(done_k - last_pop), 128'(1));
    check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    if (hold == 0) begin
      check({tag, "_first_out_latency"}, 128'(first_out - first_acc), 128'(3));
      check({tag, "_back_to_back"}, 128'(last_acc - first_acc), 128'(15));
    end else begin
      check({tag, "_accepts_under_bp"}, 128'(acc_at_release), 128'(4));
      check({tag, "_rdy_under_bp"}, rdy_at_release, 1'b0);
    end
  endtask

  initial begin
    int   n;
    logic seen_done;
    rst = 1'b1; start = 1'b0; shift = '0; relu_en = 1'b0; int4_out = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tile_done", tile_done, 1'b0);
    rst = 1'b0;

    // in_valid while idle must not be taken.
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_rdy", in_ready, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_output", out_valid, 1'b0);

    fill_t1();
    stream_tile(5'd3, 1'b0, 1'b0, 0, -1, "t1_stream");

    fill_t1();
    stream_tile(5'd3, 1'b0, 1'b0, 20, -1, "t2_bp");

    fill_t3();
    stream_tile(5'd4, 1'b1, 1'b1, 0, 4, "t3_relu_int4_restart");

    // Reset in the middle of a tile.
    fill_t4();
    @(negedge clk);
    start = 1'b1; shift = 5'd4; relu_en = 1'b0; int4_out = 1'b0;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (n == 7) break;
      in_valid = 1'b1;
      in_data  = rows[n];
      if (in_ready) n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_rows_taken", 128'(n), 128'(7));
    check("mid_out_valid_before_rst", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_tile_done", tile_done, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tile_done) seen_done = 1'b1;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (tile_done || out_valid) seen_done = 1'b1;
    end
    check("mid_no_done_or_data_after_rst", seen_done, 1'b0);

    stream_tile(5'd4, 1'b0, 1'b0, 0, -1, "t4_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
